// File: rtl/regfile_dump_reader.sv
// Walks the RegFile through one read port and streams every entry out on a valid/ready beat interface.
// Optional trailing XOR checksum beat is enabled by defining REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_reader #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int ADDR_W  = 5,
  parameter int SKIP_X0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rsR,
  input  logic [XLEN-1:0]   dataR,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [ADDR_W:0]   out_index,
  output logic              out_last,
  output logic              busy,
  output logic              core_stall,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Output handshake: a beat transfers on a rising clk edge where out_valid && out_ready;
  // while out_valid=1 and out_ready=0, out_data/out_index/out_last are held unchanged.
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(NREGS - 1);
  localparam logic [ADDR_W:0] FIRST_IDX = (ADDR_W+1)'((SKIP_X0 != 0) ? 1 : 0);

  state_t          state, state_nxt;
  logic [ADDR_W:0] ptr;
  logic            last_reg;
  logic            final_beat;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam logic [ADDR_W:0] CSUM_IDX = (ADDR_W+1)'(NREGS);
  logic [XLEN-1:0] acc;
  logic            csum_beat;
  assign final_beat = csum_beat;
`else
  assign final_beat = last_reg;
`endif

  assign last_reg = (ptr == LAST_IDX);
  assign rsR      = ptr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: state_nxt = abort ? DONE : SEND;
      SEND: begin
        if (abort)          state_nxt = DONE;
        else if (out_ready) state_nxt = final_beat ? DONE : (last_reg ? SEND : FETCH);
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == FETCH) || (state == SEND);
    core_stall = busy;
    done       = (state == DONE);
    dbg_state  = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc       <= '0;
      csum_beat <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr <= FIRST_IDX;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc       <= '0;
            csum_beat <= 1'b0;
`endif
          end
        end
        FETCH: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else begin
            out_data  <= dataR;
            out_index <= ptr;
            out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            out_last  <= 1'b0;
`else
            out_last  <= last_reg;
`endif
          end
        end
        SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (out_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc <= acc ^ out_data;
`endif
            if (final_beat) begin
              out_valid <= 1'b0;
            end else if (last_reg) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              // Checksum beat follows straight on with no read cycle.
              out_data  <= acc ^ out_data;
              out_index <= CSUM_IDX;
              out_last  <= 1'b1;
              csum_beat <= 1'b1;
`endif
            end else begin
              out_valid <= 1'b0;
              ptr       <= ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: two instances (x0 walked / x0 skipped) against a shared
// RegFile model, with a beat scoreboard per instance. Adapts to REGFILE_DUMP_CHECKSUM_EN.
module tb_regfile_dump_reader;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int ADDR_W = 5;
  localparam int W = XLEN + ADDR_W + 2;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic start1 = 1'b0;
  logic out_ready1 = 1'b1;
  logic [XLEN-1:0] regs [NREGS];

  logic [ADDR_W-1:0] rs0, rs1;
  logic [XLEN-1:0]   data0, data1, od0, od1;
  logic [ADDR_W:0]   oi0, oi1;
  logic ov0, ol0, busy0, stall0, done0;
  logic ov1, ol1, busy1, stall1, done1;
  logic [1:0] st0, st1;

  assign data0 = regs[rs0];
  assign data1 = regs[rs1];

  regfile_dump_reader #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .SKIP_X0(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rsR(rs0), .dataR(data0),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_index(oi0), .out_last(ol0),
    .busy(busy0), .core_stall(stall0), .done(done0), .dbg_state(st0));

  regfile_dump_reader #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .SKIP_X0(1)) dut_skip (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .rsR(rs1), .dataR(data1),
    .out_valid(ov1), .out_ready(out_ready1), .out_data(od1), .out_index(oi1), .out_last(ol1),
    .busy(busy1), .core_stall(stall1), .done(done1), .dbg_state(st1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done1_cnt = 0;
  bit rand_rdy = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];
  bit held = 1'b0;
  logic [W:0] held_beat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected beats {last, index, data} for one dump starting at index 'first'.
  task automatic push_exp(input int first, input bit which);
    logic [XLEN-1:0] acc;
    logic [W-1:0] item;
    acc = '0;
    for (int i = first; i < NREGS; i++) begin
      item = {(!CSUM && i == NREGS-1), (ADDR_W+1)'(i), regs[i]};
      if (which) exp1_q.push_back(item); else exp_q.push_back(item);
      acc = acc ^ regs[i];
    end
    if (CSUM) begin
      item = {1'b1, (ADDR_W+1)'(NREGS), acc};
      if (which) exp1_q.push_back(item); else exp_q.push_back(item);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input bit which, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      seen = which ? done1 : done0;
    end
    check(which ? "done1_seen" : "done_seen", 64'(seen), 64'd1);
  endtask

  // Scoreboard / protocol monitor for the x0-walking instance.
  always @(negedge clk) begin
    if (rst_n) begin
      check("stall_eq_busy", 64'(stall0), 64'(busy0));
      if (held) check("hold_stable", 64'({ov0, ol0, oi0, od0}), 64'(held_beat));
      if (ov0 && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL unexpected_beat observed=%h expected=none", {ol0, oi0, od0});
        end else begin
          check("beat", 64'({ol0, oi0, od0}), 64'(exp_q.pop_front()));
        end
      end
      held = ov0 && !out_ready && !abort;
      held_beat = {1'b1, ol0, oi0, od0};
      if (done0) done_cnt++;
    end else begin
      held = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("stall_eq_busy_skip", 64'(stall1), 64'(busy1));
      if (ov1 && out_ready1) begin
        if (exp1_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL unexpected_beat_skip observed=%h expected=none", {ol1, oi1, od1});
        end else begin
          check("beat_skip", 64'({ol1, oi1, od1}), 64'(exp1_q.pop_front()));
        end
      end
      if (done1) done1_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    int d0;
    bit found;
    for (int i = 0; i < NREGS; i++) regs[i] = XLEN'(i * 32'h11);
    regs[5] = 32'hCAFE_BABE;

    // T1 reset
    #12;
    check("rst_rsR", 64'(rs0), 64'd0);
    check("rst_valid", 64'(ov0), 64'd0);
    check("rst_data", 64'(od0), 64'd0);
    check("rst_index", 64'(oi0), 64'd0);
    check("rst_last", 64'(ol0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_stall", 64'(stall0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(5);
    check("idle_valid", 64'(ov0), 64'd0);
    check("idle_busy", 64'(busy0), 64'd0);

    // T2 full dump, ready held high, latency, start while busy ignored
    out_ready = 1'b1;
    d0 = done_cnt;
    push_exp(0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("lat_valid_n", 64'(ov0), 64'd0);
    check("lat_busy_n", 64'(busy0), 64'd1);
    @(posedge clk); #1;
    check("lat_valid_n1", 64'(ov0), 64'd1);
    check("lat_index_n1", 64'(oi0), 64'd0);
    cycles(10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, 200);
    cycles(3);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);
    check("t2_done_once", 64'(done_cnt - d0), 64'd1);
    check("t2_busy_after", 64'(busy0), 64'd0);

    // T3 random backpressure
    push_exp(0, 1'b0);
    rand_rdy = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, 600);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    cycles(2);
    check("t3_q_empty", 64'(exp_q.size()), 64'd0);

    // T4 skip-x0 instance, concurrent start/abort irrelevant here
    push_exp(1, 1'b1);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1'b1, 200);
    cycles(2);
    check("t4_q_empty", 64'(exp1_q.size()), 64'd0);
    check("t4_done_once", 64'(done1_cnt), 64'd1);

    // T5 abort in SEND at beat 10, then restart from index 0
    push_exp(0, 1'b0);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      found = ov0 && (oi0 == 6'd9);
      if (!found) begin @(posedge clk); #1; end
    end
    check("t5_reach9", 64'(found), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("t5_at10_valid", 64'(ov0), 64'd1);
    check("t5_at10_index", 64'(oi0), 64'd10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_abort_valid", 64'(ov0), 64'd0);
    check("t5_abort_done", 64'(done0), 64'd1);
    check("t5_abort_busy", 64'(busy0), 64'd0);
    check("t5_abort_last", 64'(ol0), 64'd0);
    check("t5_beats_left", 64'(exp_q.size()), 64'(NREGS - 10 + (CSUM ? 1 : 0)));
    exp_q.delete();
    cycles(2);
    check("t5_done_once", 64'(done_cnt - d0), 64'd1);
    out_ready = 1'b1;
    push_exp(0, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk); #1;
    check("t5_restart_index", 64'(oi0), 64'd0);
    wait_done(1'b0, 200);
    cycles(2);
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // T6 regs = idx; with checksum the extra beat carries XOR(0..31) = 0
    for (int i = 0; i < NREGS; i++) regs[i] = XLEN'(i);
    push_exp(0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, 200);
    cycles(2);
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-dump: outputs clear asynchronously, no done pulse
    d0 = done_cnt;
    push_exp(0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles(7);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(ov0), 64'd0);
    check("mid_rst_busy", 64'(busy0), 64'd0);
    check("mid_rst_index", 64'(oi0), 64'd0);
    check("mid_rst_done", 64'(done0), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(4);
    check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    check("mid_rst_idle", 64'(busy0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
